// File: rtl/scaled_frame_composer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : scaled_frame_composer
// Brief   : One pass per frame_start: compose scrolled map + keyed sprite,
//           fade, or clear the framebuffer through a 3-register pipeline.
// Revision: 1.0
// -----------------------------------------------------------------------------
module scaled_frame_composer #(
    parameter int          FB_W        = 240,
    parameter int          FB_H        = 160,
    parameter int          MAP_W       = 464,
    parameter int          MAP_H       = 388,
    parameter int          SPR_W       = 16,
    parameter int          SPR_H       = 21,
    parameter int          SHEET_W     = 271,
    parameter int          SPR_X       = 111,
    parameter int          SPR_Y       = 69,
    parameter int          CAM_X0      = 113,
    parameter int          CAM_Y0      = 293,
    parameter int          FADE_STEP   = 5,
    parameter logic [23:0] KEY_COLOR   = 24'hFF00FF,
    parameter logic [23:0] CLEAR_COLOR = 24'h000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [1:0]  mode,
    input  logic        cam_move,
    input  logic        cam_fast,
    input  logic [1:0]  cam_dir,
    input  logic [1:0]  spr_frame,
    output logic [18:0] map_addr,
    input  logic [23:0] map_data,
    output logic [18:0] spr_addr,
    input  logic [23:0] spr_data,
    output logic [18:0] fb_rd_addr,
    input  logic [23:0] fb_rd_data,
    output logic [18:0] fb_wr_addr,
    output logic [23:0] fb_wr_data,
    output logic        fb_we,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [9:0]  cam_x,
    output logic [9:0]  cam_y
);

    localparam logic [1:0] c_MODE_HOLD    = 2'd0;
    localparam logic [1:0] c_MODE_FADE    = 2'd1;
    localparam logic [1:0] c_MODE_COMPOSE = 2'd2;
    localparam logic [1:0] c_MODE_CLEAR   = 2'd3;
    localparam logic [9:0] c_CAM_X_MAX    = 10'(MAP_W - FB_W);
    localparam logic [9:0] c_CAM_Y_MAX    = 10'(MAP_H - FB_H);
    localparam logic [9:0] c_X_LAST       = 10'(FB_W - 1);
    localparam logic [9:0] c_Y_LAST       = 10'(FB_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_CAM, S_RUN, S_DRAIN} state_t;
    state_t r_state, w_state_next;

    logic [1:0]  r_mode, r_dir, r_frame;
    logic        r_move, r_fast, r_toggle;
    logic [9:0]  r_x, r_y, r_cam_x, r_cam_y;
    logic        r_s1_valid, r_s1_in_spr, r_s2_valid, r_s2_in_spr;
    logic [18:0] r_s1_wr_addr, r_s2_wr_addr;
    logic        r_busy, r_done, r_overrun, r_fb_we;
    logic [18:0] r_map_addr, r_spr_addr, r_fb_rd_addr, r_fb_wr_addr;
    logic [23:0] r_fb_wr_data;

    logic        w_accept, w_last_pixel, w_drain_done;
    assign w_accept     = frame_start && (r_state == S_IDLE) && !r_busy;
    assign w_last_pixel = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
    assign w_drain_done = r_fb_we && !r_s1_valid && !r_s2_valid;

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_CAM;
            S_CAM:   w_state_next = (r_mode == c_MODE_HOLD) ? S_IDLE : S_RUN;
            S_RUN:   if (w_last_pixel) w_state_next = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // A walking step happens on passes where the toggle flips to 1.
    logic [9:0] w_cam_x_next, w_cam_y_next;
    always_comb begin
        w_cam_x_next = r_cam_x;
        w_cam_y_next = r_cam_y;
        if (r_move && (r_fast || !r_toggle)) begin
            case (r_dir)
                2'd0:    if (r_cam_y < c_CAM_Y_MAX) w_cam_y_next = r_cam_y + 10'd1;
                2'd1:    if (r_cam_y > 10'd0)       w_cam_y_next = r_cam_y - 10'd1;
                2'd2:    if (r_cam_x > 10'd0)       w_cam_x_next = r_cam_x - 10'd1;
                default: if (r_cam_x < c_CAM_X_MAX) w_cam_x_next = r_cam_x + 10'd1;
            endcase
        end
    end

    int          w_dx, w_dy, w_col, w_row, w_sx;
    logic        w_in_spr;
    logic [18:0] w_pix_addr, w_map_addr_n, w_spr_addr_n;
    always_comb begin
        w_dx         = int'(r_x) - SPR_X;
        w_dy         = int'(r_y) - SPR_Y;
        w_in_spr     = (w_dx >= 0) && (w_dx < SPR_W) && (w_dy >= 0) && (w_dy < SPR_H);
        w_col        = r_move ? (int'(r_frame) + (r_fast ? 3 : 0)) : 1;
        // Right-facing frames reuse the left-facing row, mirrored horizontally.
        w_row        = (r_dir == 2'd3) ? 2 : int'(r_dir);
        w_sx         = (r_dir == 2'd3) ? (SPR_W - 1 - w_dx) : w_dx;
        w_spr_addr_n = 19'((w_row * SPR_H + w_dy) * SHEET_W + w_col * SPR_W + w_sx);
        w_map_addr_n = 19'((int'(r_y) + int'(r_cam_y)) * MAP_W + int'(r_x) + int'(r_cam_x));
        w_pix_addr   = 19'(int'(r_y) * FB_W + int'(r_x));
    end

    function automatic logic [7:0] fade_ch(input logic [7:0] c);
        int t;
        t = int'(c) - FADE_STEP;
        return (t < 0) ? 8'd0 : 8'(t);
    endfunction

    logic [23:0] w_pixel;
    always_comb begin
        w_pixel = map_data;
        case (r_mode)
            c_MODE_FADE:  w_pixel = {fade_ch(fb_rd_data[23:16]), fade_ch(fb_rd_data[15:8]),
                                     fade_ch(fb_rd_data[7:0])};
            c_MODE_CLEAR: w_pixel = CLEAR_COLOR;
            default:      if (r_s2_in_spr && (spr_data != KEY_COLOR)) w_pixel = spr_data;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
            r_toggle     <= 1'b0;
            r_fb_we      <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s1_in_spr  <= 1'b0;
            r_s2_in_spr  <= 1'b0;
            r_s1_wr_addr <= 19'd0;
            r_s2_wr_addr <= 19'd0;
            r_cam_x      <= 10'(CAM_X0);
            r_cam_y      <= 10'(CAM_Y0);
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_mode       <= c_MODE_HOLD;
            r_dir        <= 2'd0;
            r_frame      <= 2'd0;
            r_move       <= 1'b0;
            r_fast       <= 1'b0;
            r_map_addr   <= 19'd0;
            r_spr_addr   <= 19'd0;
            r_fb_rd_addr <= 19'd0;
            r_fb_wr_addr <= 19'd0;
            r_fb_wr_data <= 24'd0;
        end else begin
            r_done       <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= r_s1_valid;
            r_s2_in_spr  <= r_s1_in_spr;
            r_s2_wr_addr <= r_s1_wr_addr;
            r_fb_we      <= r_s2_valid;
            r_fb_wr_addr <= r_s2_wr_addr;
            r_fb_wr_data <= w_pixel;
            if (frame_start && r_busy) r_overrun <= 1'b1;
            if (w_accept) begin
                r_busy  <= 1'b1;
                r_mode  <= mode;
                r_move  <= cam_move;
                r_fast  <= cam_fast;
                r_dir   <= cam_dir;
                r_frame <= spr_frame;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                S_CAM: begin
                    r_x <= 10'd0;
                    r_y <= 10'd0;
                    if (r_mode == c_MODE_HOLD) r_done <= 1'b1;
                    if (r_mode == c_MODE_COMPOSE) begin
                        r_cam_x  <= w_cam_x_next;
                        r_cam_y  <= w_cam_y_next;
                        r_toggle <= ~r_toggle;
                    end
                end
                S_RUN: begin
                    r_s1_valid   <= 1'b1;
                    r_s1_in_spr  <= w_in_spr;
                    r_s1_wr_addr <= w_pix_addr;
                    r_map_addr   <= w_map_addr_n;
                    r_spr_addr   <= w_spr_addr_n;
                    r_fb_rd_addr <= w_pix_addr;
                    if (r_x == c_X_LAST) begin
                        r_x <= 10'd0;
                        r_y <= r_y + 10'd1;
                    end else begin
                        r_x <= r_x + 10'd1;
                    end
                end
                S_DRAIN: if (w_drain_done) r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign map_addr   = r_map_addr;
    assign spr_addr   = r_spr_addr;
    assign fb_rd_addr = r_fb_rd_addr;
    assign fb_wr_addr = r_fb_wr_addr;
    assign fb_wr_data = r_fb_wr_data;
    assign fb_we      = r_fb_we;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overrun    = r_overrun;
    assign cam_x      = r_cam_x;
    assign cam_y      = r_cam_y;

endmodule
`default_nettype wire

// File: tb/tb_scaled_frame_composer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : tb_scaled_frame_composer
// Brief   : Directed bench on a 4x2 framebuffer over an 8x4 map, 2x1 sprite.
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_scaled_frame_composer;

    logic        clk = 1'b0;
    logic        Reset, frame_start, cam_move, cam_fast;
    logic [1:0]  mode, cam_dir, spr_frame;
    logic [18:0] map_addr, spr_addr, fb_rd_addr, fb_wr_addr;
    logic [23:0] map_data, spr_data, fb_rd_data, fb_wr_data;
    logic        fb_we, busy, done, overrun;
    logic [9:0]  cam_x, cam_y;

    int          total, bad, nwr, done_cyc, ecx, ecy;
    logic        busy_ok, spr_test;
    logic [18:0] wa [8];
    logic [23:0] wd [8];
    int          c_dirs [13] = '{0, 3, 3, 3, 3, 2, 2, 2, 2, 2, 1, 1, 1};
    int          c_ex   [13] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 0, 0, 0};
    int          c_ey   [13] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 1, 0, 0};

    always #5 clk = ~clk;

    scaled_frame_composer #(
        .FB_W(4), .FB_H(2), .MAP_W(8), .MAP_H(4),
        .SPR_W(2), .SPR_H(1), .SHEET_W(16), .SPR_X(0), .SPR_Y(0),
        .CAM_X0(1), .CAM_Y0(0), .FADE_STEP(5),
        .KEY_COLOR(24'hFF00FF), .CLEAR_COLOR(24'h0A0B0C)
    ) dut (
        .Clk(clk), .Reset(Reset), .frame_start(frame_start), .mode(mode),
        .cam_move(cam_move), .cam_fast(cam_fast), .cam_dir(cam_dir), .spr_frame(spr_frame),
        .map_addr(map_addr), .map_data(map_data), .spr_addr(spr_addr), .spr_data(spr_data),
        .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .fb_we(fb_we),
        .busy(busy), .done(done), .overrun(overrun), .cam_x(cam_x), .cam_y(cam_y)
    );

    function automatic logic [23:0] map_fn(input int a);
        return 24'h100000 | 24'(a);
    endfunction

    // One-cycle-latency memories; sprite cells at addr 2 and 34 hold the key colour.
    always @(posedge clk) begin
        map_data   <= map_fn(int'(map_addr));
        spr_data   <= (spr_test && spr_addr != 19'd2 && spr_addr != 19'd34) ? 24'h123456 : 24'hFF00FF;
        fb_rd_data <= {8'h03, 8'hFF, 8'h10 + fb_rd_addr[7:0]};
    end

    function automatic logic [23:0] exp_pix(input logic [1:0] m, input int i, input int d);
        int x, y;
        x = i % 4;
        y = i / 4;
        if (m == 2'd1) return {8'h00, 8'hFA, 8'h0B + 8'(i)};
        if (m == 2'd3) return 24'h0A0B0C;
        if (spr_test && y == 0 && ((d != 3 && x == 1) || (d == 3 && x == 0))) return 24'h123456;
        return map_fn((y + ecy) * 8 + x + ecx);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic run_pass(input logic [1:0] m, input logic mv, input logic fs,
                            input logic [1:0] d, input int poke, input int abort_at);
        int cyc;
        mode = m; cam_move = mv; cam_fast = fs; cam_dir = d; spr_frame = 2'd0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        nwr = 0; done_cyc = -1; busy_ok = 1'b1; cyc = 0;
        while (done_cyc < 0 && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (fb_we) begin
                if (nwr < 8) begin
                    wa[nwr] = fb_wr_addr;
                    wd[nwr] = fb_wr_data;
                end
                nwr++;
            end
            if (done) done_cyc = cyc;
            if (abort_at > 0 && nwr == abort_at) begin
                Reset = 1'b1;
                @(negedge clk);
                check("abort_we", 32'(fb_we), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_camx", 32'(cam_x), 32'd1);
                check("abort_camy", 32'(cam_y), 32'd0);
                check("abort_ovr", 32'(overrun), 32'd0);
                Reset = 1'b0;
                return;
            end
            frame_start = (cyc == poke);
            if (done_cyc < 0) @(negedge clk);
            cyc++;
        end
        frame_start = 1'b0;
    endtask

    task automatic check_pass(input string tag, input logic [1:0] m, input int d);
        check({tag, "_cnt"}, 32'(nwr), (m == 2'd0) ? 32'd0 : 32'd8);
        check({tag, "_done"}, 32'(done_cyc), (m == 2'd0) ? 32'd1 : 32'd12);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        if (m != 2'd0) begin
            for (int i = 0; i < 8; i++) begin
                check({tag, "_addr"}, 32'(wa[i]), 32'(i));
                check({tag, "_data"}, 32'(wd[i]), 32'(exp_pix(m, i, d)));
            end
        end
        check({tag, "_camx"}, 32'(cam_x), 32'(ecx));
        check({tag, "_camy"}, 32'(cam_y), 32'(ecy));
        @(negedge clk);
        check({tag, "_idle"}, 32'({busy, fb_we}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        Reset = 1'b1; frame_start = 1'b0; mode = 2'd0; cam_move = 1'b0;
        cam_fast = 1'b0; cam_dir = 2'd0; spr_frame = 2'd0; spr_test = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(fb_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_camx", 32'(cam_x), 32'd1);
        check("rst_camy", 32'(cam_y), 32'd0);
        Reset = 1'b0;
        @(negedge clk);
        ecx = 1; ecy = 0;

        run_pass(2'd2, 1'b0, 1'b0, 2'd0, -1, 0);
        check_pass("compose", 2'd2, 0);
        run_pass(2'd0, 1'b1, 1'b1, 2'd3, -1, 0);
        check_pass("hold", 2'd0, 3);

        // Walking speed: the camera steps on every other compose pass.
        do_reset();
        run_pass(2'd2, 1'b1, 1'b0, 2'd0, -1, 0); ecy = 1;
        check_pass("walk1", 2'd2, 0);
        run_pass(2'd2, 1'b1, 1'b0, 2'd0, -1, 0); ecy = 1;
        check_pass("walk2", 2'd2, 0);
        run_pass(2'd2, 1'b1, 1'b0, 2'd0, -1, 0); ecy = 2;
        check_pass("walk3", 2'd2, 0);

        for (int k = 0; k < 13; k++) begin
            run_pass(2'd2, 1'b1, 1'b1, 2'(c_dirs[k]), -1, 0);
            ecx = c_ex[k]; ecy = c_ey[k];
            check_pass("clamp", 2'd2, c_dirs[k]);
        end

        run_pass(2'd1, 1'b1, 1'b1, 2'd0, -1, 0);
        check_pass("fade", 2'd1, 0);
        run_pass(2'd3, 1'b1, 1'b1, 2'd3, -1, 0);
        check_pass("clear", 2'd3, 3);

        spr_test = 1'b1;
        run_pass(2'd2, 1'b0, 1'b0, 2'd0, -1, 0);
        check_pass("spr_d0", 2'd2, 0);
        run_pass(2'd2, 1'b0, 1'b0, 2'd3, -1, 0);
        check_pass("spr_d3", 2'd2, 3);
        spr_test = 1'b0;

        check("ovr_before", 32'(overrun), 32'd0);
        run_pass(2'd2, 1'b0, 1'b0, 2'd0, 3, 0);
        check_pass("ovr_pass", 2'd2, 0);
        check("ovr_after", 32'(overrun), 32'd1);

        run_pass(2'd2, 1'b1, 1'b1, 2'd0, -1, 3);
        @(negedge clk);
        ecx = 1; ecy = 0;
        run_pass(2'd2, 1'b0, 1'b0, 2'd0, -1, 0);
        check_pass("post_abort", 2'd2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scaled_frame_composer.md
SCALED_FRAME_COMPOSER -- requirements
Module: scaled_frame_composer

Interface
REQ-001 SHALL have parameter FB_W, default 240, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_H, default 160, framebuffer height in pixels.
REQ-003 SHALL have parameters MAP_W, MAP_H, defaults 464, 388: background map size; MAP_W>=FB_W, MAP_H>=FB_H.
REQ-004 SHALL have parameters SPR_W, SPR_H, SHEET_W, defaults 16, 21, 271: sprite cell size and sprite sheet row pitch.
REQ-005 SHALL have parameters SPR_X, SPR_Y, defaults 111, 69: sprite box top-left in framebuffer coordinates.
REQ-006 SHALL have parameters CAM_X0, CAM_Y0, defaults 113, 293; FADE_STEP, default 5; KEY_COLOR, default 24'hFF00FF; CLEAR_COLOR, default 24'h000000.
REQ-007 Clk  in  1  single clock, all logic on its rising edge.
REQ-008 Reset  in  1  synchronous, active-high.
REQ-009 frame_start  in  1  one-cycle pulse requesting one composition pass.
REQ-010 mode  in  2  0 hold, 1 fade, 2 compose, 3 clear; sampled only at accepted frame_start.
REQ-011 cam_move, cam_fast  in  1 each  character walking / running.
REQ-012 cam_dir  in  2  0 down, 1 up, 2 left, 3 right.
REQ-013 spr_frame  in  2  animation column 0..2 while moving.
REQ-014 map_addr  out  19; map_data  in  24  background ROM, data valid one cycle after address.
REQ-015 spr_addr  out  19; spr_data  in  24  sprite ROM, one-cycle latency.
REQ-016 fb_rd_addr  out  19; fb_rd_data  in  24  framebuffer read port, one-cycle latency.
REQ-017 fb_wr_addr  out  19; fb_wr_data  out  24; fb_we  out  1  framebuffer write port.
REQ-018 busy, done, overrun  out  1 each; cam_x, cam_y  out  10 each.

Function
REQ-019 SHALL implement FSM IDLE -> CAM -> RUN -> DRAIN -> IDLE; IDLE accepts frame_start only.
REQ-020 On accepted frame_start SHALL latch mode, cam_move, cam_fast, cam_dir, spr_frame; go to CAM next cycle; mode 0 returns directly to IDLE with done pulse, no writes.
REQ-021 CAM (one cycle): if latched cam_move and (cam_fast or toggle=1) move camera 1 pixel in cam_dir; toggle inverts every accepted compose pass.
REQ-022 Camera SHALL clamp to cam_x in [0, MAP_W-FB_W], cam_y in [0, MAP_H-FB_H]; a move at a bound leaves the coordinate unchanged, no wrap.
REQ-023 Camera update SHALL occur only in compose mode; fade/clear leave cam_x, cam_y unchanged.
REQ-024 RUN SHALL walk (x,y) raster order, x fastest, issuing one pixel address per cycle for FB_W*FB_H cycles.
REQ-025 Addresses registered in cycle k; data used in k+1; fb_we/fb_wr_addr/fb_wr_data registered, valid in k+2; fb_wr_addr = y*FB_W+x.
REQ-026 Compose: map_addr=(y+cam_y)*MAP_W+(x+cam_x); pixel=map_data unless inside sprite box and spr_data!=KEY_COLOR, then spr_data.
REQ-027 Sprite address: dx,dy box offsets; col = cam_move ? spr_frame+3*cam_fast : 1; dir 0..2 row=(cam_dir*SPR_H+dy)*SHEET_W+col*SPR_W+dx; dir 3 uses row 2 with dx replaced by SPR_W-1-dx.
REQ-028 Fade: fb_rd_addr=y*FB_W+x; each 8-bit channel of fb_rd_data minus FADE_STEP, saturating at 0.
REQ-029 Clear: every pixel written CLEAR_COLOR; ROM/read addresses don't-care.
REQ-030 DRAIN SHALL flush the 2-stage pipeline; done pulses one cycle after the last fb_we, then IDLE.
REQ-031 busy SHALL be 1 from the cycle after accepted frame_start through the done cycle inclusive.
REQ-032 frame_start while busy SHALL be ignored and set overrun (sticky until Reset).
REQ-033 fb_we SHALL be 0 outside RUN/DRAIN pipeline write slots; exactly FB_W*FB_H writes per fade/compose/clear pass.

Reset
REQ-034 Reset SHALL force IDLE, fb_we=0, busy=0, done=0, overrun=0, toggle=0, cam_x=CAM_X0, cam_y=CAM_Y0, pipeline valids cleared.
REQ-035 Reset mid-pass SHALL abort immediately; no fb_we in the cycle after Reset is sampled.

Verification (FB_W=4, FB_H=2, MAP_W=8, MAP_H=4, SPR box outside FB unless noted)
REQ-036 Reset, then compose, no move -> 8 writes, addrs 0..7, data = map[(y+cam_y)*8+x+cam_x], done 1 cycle after 8th write.
REQ-037 cam_x=4 (max), cam_dir=3, cam_fast=1, compose -> cam_x stays 4; cam_x=0, dir 2 -> stays 0.
REQ-038 cam_move=1, cam_fast=0, three compose passes, dir 0 from cam_y=0 -> cam_y 1,1,2.
REQ-039 Fade with fb_rd_data=24'h03FF10, FADE_STEP=5 -> fb_wr_data=24'h00FA0B.
REQ-040 SPR_X=0, SPR_Y=0, spr_data=KEY_COLOR at dx=0, else 24'h123456 -> pixel (0,0) map data, (1,0) 24'h123456; dir 3 reads mirrored dx.
REQ-041 frame_start during RUN -> ignored, overrun=1; Reset at 3rd write -> fb_we=0 next cycle, cam back to CAM_X0/CAM_Y0.
